// File: rtl/g5_apblink_pkg.sv
// Shared definitions for the G5 APBLink initiator and slave:
// link command codes, slave FSM states, marker layout and lane helpers.
package g5_apblink_pkg;

  // Link commands carried on lnk_s_addr[1:0] while the slave is idle.
  localparam logic [1:0] CMD_NOOP  = 2'b00;
  localparam logic [1:0] CMD_WRITE = 2'b10;
  localparam logic [1:0] CMD_READ  = 2'b01;
  localparam logic [1:0] CMD_POLL  = 2'b11;

  // Bit positions inside the returned marker nibble.
  localparam int unsigned MARK_RDY_BIT = 2;
  localparam int unsigned MARK_ERR_BIT = 3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_SETUP,
    S_ACCESS,
    S_MARK,
    S_RDATA
  } state_e;

  // Marker nibble: ready always set, error as reported.
  function automatic logic [3:0] marker_of(input logic err);
    logic [3:0] m;
    m               = '0;
    m[MARK_RDY_BIT] = 1'b1;
    m[MARK_ERR_BIT] = err;
    return m;
  endfunction

  // Lane k carries bit 0 of byte k.
  function automatic logic [3:0] lanes_of(input logic [31:0] d);
    return {d[24], d[16], d[8], d[0]};
  endfunction

  // Shift every byte right by one so the next bit reaches the lane position.
  function automatic logic [31:0] byte_shr(input logic [31:0] d);
    return {1'b0, d[31:25], 1'b0, d[23:17], 1'b0, d[15:9], 1'b0, d[7:1]};
  endfunction

endpackage

// File: rtl/g5_apblink_lane_deser.sv
// Address / write-data deserialiser for the APBLink slave.
// Each address lane and each data lane feeds its own byte, LSB first.
module g5_apblink_lane_deser
  import g5_apblink_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        load_i,
  input  logic        shift_i,
  input  logic [2:0]  addr_lane_i,
  input  logic [3:0]  data_lane_i,
  output logic        last_o,
  output logic [23:0] addr_nxt_o,
  output logic [31:0] data_nxt_o
);

  logic [2:0]  cnt_q;
  logic [23:0] addr_q, addr_d;
  logic [31:0] data_q, data_d;

  // Next-state of the shift registers; exported so the final bit can be
  // used in the same cycle it arrives.
  always_comb begin
    addr_d = addr_q;
    data_d = data_q;
    if (shift_i) begin
      addr_d = {addr_lane_i[2], addr_q[23:17],
                addr_lane_i[1], addr_q[15:9],
                addr_lane_i[0], addr_q[7:1]};
      data_d = {data_lane_i[3], data_q[31:25],
                data_lane_i[2], data_q[23:17],
                data_lane_i[1], data_q[15:9],
                data_lane_i[0], data_q[7:1]};
    end
  end

  // Bit counter and shift registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q  <= '0;
      addr_q <= '0;
      data_q <= '0;
    end else begin
      if (load_i) begin
        cnt_q <= '0;
      end else if (shift_i) begin
        cnt_q <= cnt_q + 3'd1;
      end
      addr_q <= addr_d;
      data_q <= data_d;
    end
  end

  assign last_o     = shift_i && (cnt_q == 3'd7);
  assign addr_nxt_o = addr_d;
  assign data_nxt_o = data_d;

endmodule

// File: rtl/g5_apblink_slave.sv
// G5 APBLink far-end slave: decodes link commands, replays them as APB
// master cycles and returns marker plus serialised read data.
module g5_apblink_slave
  import g5_apblink_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic        pclk,
  input  logic        preset,
  input  logic        lnk_s_enable,
  input  logic [2:0]  lnk_s_addr,
  input  logic [3:0]  lnk_s_wdata,
  output logic [3:0]  lnk_s_rdata,
  output logic        m_psel,
  output logic        m_penable,
  output logic        m_pwrite,
  output logic [25:0] m_paddr,
  output logic [31:0] m_pwdata,
  output logic [3:0]  m_pstrb,
  input  logic [31:0] m_prdata,
  input  logic        m_pready,
  input  logic        m_pslverr
);

  localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TO_LAST = (TIMEOUT_CYCLES == 0) ? '0 : TW'(TIMEOUT_CYCLES - 1);

  state_e        state_q;
  logic [23:0]   held_addr_q;
  logic [31:0]   rsh_q;
  logic [2:0]    rcnt_q;
  logic [TW-1:0] to_cnt_q;
  logic          psel_q, penable_q, pwrite_q;
  logic [25:0]   paddr_q;
  logic [31:0]   pwdata_q;
  logic [3:0]    pstrb_q;
  logic [3:0]    lnk_rdata_q;

  logic [1:0]    cmd;
  logic          accept_rw;
  logic          shift_en;
  logic          deser_last;
  logic [23:0]   addr_nxt;
  logic [31:0]   data_nxt;
  logic          timeout_hit;

  assign cmd         = lnk_s_addr[1:0];
  assign accept_rw   = (state_q == S_IDLE) && lnk_s_enable &&
                       ((cmd == CMD_WRITE) || (cmd == CMD_READ));
  assign shift_en    = (state_q == S_ADDR);
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (to_cnt_q == TO_LAST);

  g5_apblink_lane_deser u_deser (
    .clk_i       (pclk),
    .rst_i       (preset),
    .load_i      (accept_rw),
    .shift_i     (shift_en),
    .addr_lane_i (lnk_s_addr),
    .data_lane_i (lnk_s_wdata),
    .last_o      (deser_last),
    .addr_nxt_o  (addr_nxt),
    .data_nxt_o  (data_nxt)
  );

  // Link/APB sequencing FSM with registered APB and link outputs.
  always_ff @(posedge pclk) begin
    if (preset) begin
      state_q     <= S_IDLE;
      held_addr_q <= '0;
      rsh_q       <= '0;
      rcnt_q      <= '0;
      to_cnt_q    <= '0;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      pstrb_q     <= '0;
      lnk_rdata_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          lnk_rdata_q <= '0;
          if (lnk_s_enable) begin
            case (cmd)
              CMD_WRITE, CMD_READ: begin
                pwrite_q <= (cmd == CMD_WRITE);
                pstrb_q  <= (cmd == CMD_WRITE) ? lnk_s_wdata : 4'h0;
                state_q  <= S_ADDR;
              end
              CMD_POLL: begin
                pwrite_q <= 1'b0;
                pstrb_q  <= '0;
                pwdata_q <= '0;
                paddr_q  <= {held_addr_q, 2'b00};
                psel_q   <= 1'b1;
                state_q  <= S_SETUP;
              end
              default: ;
            endcase
          end
        end
        S_ADDR: begin
          if (deser_last) begin
            held_addr_q <= addr_nxt;
            paddr_q     <= {addr_nxt, 2'b00};
            pwdata_q    <= pwrite_q ? data_nxt : '0;
            psel_q      <= 1'b1;
            state_q     <= S_SETUP;
          end
        end
        S_SETUP: begin
          penable_q <= 1'b1;
          to_cnt_q  <= '0;
          state_q   <= S_ACCESS;
        end
        S_ACCESS: begin
          if (m_pready) begin
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            rsh_q       <= m_prdata;
            lnk_rdata_q <= marker_of(m_pslverr);
            state_q     <= S_MARK;
          end else if (timeout_hit) begin
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            rsh_q       <= '0;
            lnk_rdata_q <= marker_of(1'b1);
            state_q     <= S_MARK;
          end else begin
            to_cnt_q <= to_cnt_q + 1'b1;
          end
        end
        S_MARK: begin
          if (pwrite_q) begin
            lnk_rdata_q <= '0;
            state_q     <= S_IDLE;
          end else begin
            lnk_rdata_q <= lanes_of(rsh_q);
            rsh_q       <= byte_shr(rsh_q);
            rcnt_q      <= '0;
            state_q     <= S_RDATA;
          end
        end
        S_RDATA: begin
          if (rcnt_q == 3'd7) begin
            lnk_rdata_q <= '0;
            state_q     <= S_IDLE;
          end else begin
            lnk_rdata_q <= lanes_of(rsh_q);
            rsh_q       <= byte_shr(rsh_q);
            rcnt_q      <= rcnt_q + 3'd1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign lnk_s_rdata = lnk_rdata_q;
  assign m_psel      = psel_q;
  assign m_penable   = penable_q;
  assign m_pwrite    = pwrite_q;
  assign m_paddr     = paddr_q;
  assign m_pwdata    = pwdata_q;
  assign m_pstrb     = pstrb_q;

endmodule

// File: tb/tb_g5_apblink_slave.sv
// Scoreboard bench for g5_apblink_slave: stimulus pushes expected APB
// transfers and link responses; an APB target model and a link monitor
// pop and compare them as the DUT presents them.
module tb_g5_apblink_slave;
  import g5_apblink_pkg::*;

  logic        pclk = 1'b0;
  logic        preset;
  logic        lnk_s_enable;
  logic [2:0]  lnk_s_addr;
  logic [3:0]  lnk_s_wdata;
  logic [3:0]  lnk_s_rdata;
  logic        m_psel, m_penable, m_pwrite;
  logic [25:0] m_paddr;
  logic [31:0] m_pwdata;
  logic [3:0]  m_pstrb;
  logic [31:0] m_prdata;
  logic        m_pready, m_pslverr;

  always #5 pclk = ~pclk;

  g5_apblink_slave #(.TIMEOUT_CYCLES(16)) dut (
    .pclk        (pclk),
    .preset      (preset),
    .lnk_s_enable(lnk_s_enable),
    .lnk_s_addr  (lnk_s_addr),
    .lnk_s_wdata (lnk_s_wdata),
    .lnk_s_rdata (lnk_s_rdata),
    .m_psel      (m_psel),
    .m_penable   (m_penable),
    .m_pwrite    (m_pwrite),
    .m_paddr     (m_paddr),
    .m_pwdata    (m_pwdata),
    .m_pstrb     (m_pstrb),
    .m_prdata    (m_prdata),
    .m_pready    (m_pready),
    .m_pslverr   (m_pslverr)
  );

  typedef struct {
    logic [25:0] addr;
    bit          wr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    int          setup_cyc;
    int          waits;
    bit          hang;
    logic [31:0] rdata;
    bit          err;
  } apb_t;

  typedef struct {
    logic [3:0]  marker;
    bit          is_read;
    logic [31:0] rdata;
    int          mark_cyc;
  } lnk_t;

  apb_t apb_q[$];
  lnk_t lnk_q[$];
  int   pend_apb = 0;
  int   pend_lnk = 0;
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  bit   mon_off = 1'b0;

  always @(posedge pclk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic zero_check(input string nm);
    chk({nm, "_apbctl"}, {m_psel, m_penable, m_pwrite, m_pstrb, m_paddr}, '0);
    chk({nm, "_pwdata"}, m_pwdata, '0);
    chk({nm, "_lanes"}, lnk_s_rdata, '0);
  endtask

  task automatic push_apb(input logic [25:0] addr, input bit wr, input logic [31:0] wdata,
                          input logic [3:0] strb, input int setup_cyc, input int waits,
                          input bit hang, input logic [31:0] rdata, input bit err);
    apb_t e;
    e.addr = addr; e.wr = wr; e.wdata = wdata; e.strb = strb; e.setup_cyc = setup_cyc;
    e.waits = waits; e.hang = hang; e.rdata = rdata; e.err = err;
    apb_q.push_back(e);
    pend_apb++;
  endtask

  task automatic push_lnk(input logic [3:0] marker, input bit is_read,
                          input logic [31:0] rdata, input int mark_cyc);
    lnk_t e;
    e.marker = marker; e.is_read = is_read; e.rdata = rdata; e.mark_cyc = mark_cyc;
    lnk_q.push_back(e);
    pend_lnk++;
  endtask

  // Called at a negedge: the command is presented in the current cycle (T0).
  task automatic issue(input logic [1:0] cmd, input logic en, input logic [25:0] addr,
                       input logic [31:0] data, input logic [3:0] strb, input int nl);
    logic [23:0] a;
    a = addr[25:2];
    lnk_s_enable = en;
    lnk_s_addr   = {1'b0, cmd};
    lnk_s_wdata  = strb;
    for (int i = 0; i < nl; i++) begin
      @(negedge pclk);
      lnk_s_enable = 1'b0;
      lnk_s_addr   = {a[16+i], a[8+i], a[i]};
      lnk_s_wdata  = {data[24+i], data[16+i], data[8+i], data[i]};
    end
    @(negedge pclk);
    lnk_s_enable = 1'b0;
    lnk_s_addr   = '0;
    lnk_s_wdata  = '0;
  endtask

  task automatic wait_done(input string nm);
    int n;
    n = 0;
    while ((pend_apb != 0 || pend_lnk != 0) && n < 3000) begin
      @(negedge pclk);
      n++;
    end
    chk({nm, "_drain"}, pend_apb + pend_lnk, 0);
    if (pend_apb != 0 || pend_lnk != 0) begin
      apb_q.delete(); lnk_q.delete();
      pend_apb = 0; pend_lnk = 0;
    end
    repeat (2) @(negedge pclk);
  endtask

  // APB target model: checks each transfer at SETUP and answers in ACCESS.
  apb_t cur;
  int   wcnt;
  bit   active;
  initial begin
    m_pready = 1'b0; m_prdata = '0; m_pslverr = 1'b0;
    active = 1'b0; wcnt = 0;
    forever begin
      @(negedge pclk);
      if (preset) begin
        m_pready = 1'b0; m_pslverr = 1'b0; m_prdata = '0; active = 1'b0;
      end else if (m_psel && !m_penable) begin
        m_pready = 1'b0; m_pslverr = 1'b0; m_prdata = 32'h5555_5555;
        wcnt = 0;
        if (apb_q.size() == 0) begin
          chk("apb_unexpected_setup", 1, 0);
          active = 1'b0;
        end else begin
          cur = apb_q.pop_front();
          active = 1'b1;
          chk("apb_paddr", m_paddr, cur.addr);
          chk("apb_pwrite", m_pwrite, cur.wr);
          chk("apb_pstrb", m_pstrb, cur.strb);
          if (cur.wr) chk("apb_pwdata", m_pwdata, cur.wdata);
          chk("apb_setup_cycle", cyc, cur.setup_cyc);
          pend_apb--;
        end
      end else if (m_psel && m_penable) begin
        if (active) begin
          chk("apb_hold", {m_paddr, m_pwrite, m_pstrb}, {cur.addr, cur.wr, cur.strb});
          if (cur.wr) chk("apb_hold_wdata", m_pwdata, cur.wdata);
        end
        m_pready  = active && !cur.hang && (wcnt == cur.waits);
        m_pslverr = m_pready && cur.err;
        m_prdata  = m_pready ? cur.rdata : 32'h5555_5555;
        wcnt++;
      end else begin
        m_pready = 1'b0; m_pslverr = 1'b0; m_prdata = '0; active = 1'b0;
      end
    end
  end

  // Link monitor: a set ready bit outside a read burst is a marker.
  initial begin
    lnk_t        e;
    logic [31:0] got;
    forever begin
      @(negedge pclk);
      if (!mon_off && !preset && lnk_s_rdata[MARK_RDY_BIT]) begin
        if (lnk_q.size() == 0) begin
          chk("lnk_unexpected_marker", lnk_s_rdata, 0);
        end else begin
          e = lnk_q.pop_front();
          chk("lnk_marker", lnk_s_rdata, e.marker);
          chk("lnk_marker_cycle", cyc, e.mark_cyc);
          chk("lnk_psel_dropped", {m_psel, m_penable}, 2'b00);
          if (e.is_read) begin
            got = '0;
            for (int i = 0; i < 8; i++) begin
              @(negedge pclk);
              for (int k = 0; k < 4; k++) got[8*k+i] = lnk_s_rdata[k];
            end
            chk("lnk_rdata", got, e.rdata);
          end
          @(negedge pclk);
          chk("lnk_lanes_idle", lnk_s_rdata, 4'h0);
          pend_lnk--;
        end
      end
    end
  end

  initial begin
    repeat (60000) @(posedge pclk);
    $display("FAIL watchdog: cycles=%0d limit=60000", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    int t1;
    preset = 1'b1; lnk_s_enable = 1'b0; lnk_s_addr = '0; lnk_s_wdata = '0;
    repeat (3) @(negedge pclk);
    zero_check("reset");
    preset = 1'b0;
    @(negedge pclk);

    // POLL straight after reset reads address 0
    t0 = cyc;
    push_apb(26'h0, 0, 0, 4'h0, t0 + 1, 0, 0, 32'h00C0FFEE, 0);
    push_lnk(4'b0100, 1, 32'h00C0FFEE, t0 + 3);
    issue(CMD_POLL, 1'b1, 26'h0, 32'h0, 4'h0, 0);
    wait_done("poll_reset");

    // WRITE, then POLL presented exactly at T12
    t0 = cyc;
    push_apb(26'h0ABCDE4, 1, 32'hA5A51234, 4'hF, t0 + 9, 0, 0, 32'h0, 0);
    push_lnk(4'b0100, 0, 32'h0, t0 + 11);
    issue(CMD_WRITE, 1'b1, 26'h0ABCDE4, 32'hA5A51234, 4'hF, 8);
    while (cyc != t0 + 12) @(negedge pclk);
    t1 = cyc;
    push_apb(26'h0ABCDE4, 0, 0, 4'h0, t1 + 1, 0, 0, 32'h13572468, 0);
    push_lnk(4'b0100, 1, 32'h13572468, t1 + 3);
    issue(CMD_POLL, 1'b1, 26'h0, 32'h0, 4'h0, 0);
    wait_done("write_poll");

    // READ with 3 wait states; strobe lanes set but pstrb must be 0
    t0 = cyc;
    push_apb(26'h0000100, 0, 0, 4'h0, t0 + 9, 3, 0, 32'hDEADBEEF, 0);
    push_lnk(4'b0100, 1, 32'hDEADBEEF, t0 + 14);
    issue(CMD_READ, 1'b1, 26'h0000100, 32'hFFFFFFFF, 4'hF, 8);
    wait_done("read_wait3");

    // POLL re-reads the held address
    t0 = cyc;
    push_apb(26'h0000100, 0, 0, 4'h0, t0 + 1, 1, 0, 32'h11223344, 0);
    push_lnk(4'b0100, 1, 32'h11223344, t0 + 4);
    issue(CMD_POLL, 1'b1, 26'h0, 32'h0, 4'h0, 0);
    wait_done("poll_held");

    // WRITE with slave error
    t0 = cyc;
    push_apb(26'h3FFFFFC, 1, 32'h0F0F0F0F, 4'h5, t0 + 9, 2, 0, 32'h0, 1);
    push_lnk(4'b1100, 0, 32'h0, t0 + 13);
    issue(CMD_WRITE, 1'b1, 26'h3FFFFFC, 32'h0F0F0F0F, 4'h5, 8);
    wait_done("write_err");

    // READ with slave error still returns data
    t0 = cyc;
    push_apb(26'h1234568, 0, 0, 4'h0, t0 + 9, 0, 0, 32'hCAFEF00D, 1);
    push_lnk(4'b1100, 1, 32'hCAFEF00D, t0 + 11);
    issue(CMD_READ, 1'b1, 26'h1234568, 32'h0, 4'h0, 8);
    wait_done("read_err");

    // Timeout after 16 ACCESS cycles: error marker, zero data
    t0 = cyc;
    push_apb(26'h2000000, 0, 0, 4'h0, t0 + 9, 0, 1, 32'h0, 0);
    push_lnk(4'b1100, 1, 32'h0, t0 + 26);
    issue(CMD_READ, 1'b1, 26'h2000000, 32'h0, 4'h0, 8);
    wait_done("timeout");

    // Reset in the middle of S_ADDR
    issue(CMD_WRITE, 1'b1, 26'h1555554, 32'h12345678, 4'hF, 3);
    preset = 1'b1;
    @(negedge pclk);
    zero_check("rst_addr");
    preset = 1'b0;
    @(negedge pclk);
    t0 = cyc;
    push_apb(26'h0, 0, 0, 4'h0, t0 + 1, 0, 0, 32'h5A5A5A5A, 0);
    push_lnk(4'b0100, 1, 32'h5A5A5A5A, t0 + 3);
    issue(CMD_POLL, 1'b1, 26'h0, 32'h0, 4'h0, 0);
    wait_done("poll_after_rst_addr");

    // Reset in the middle of S_RDATA
    mon_off = 1'b1;
    t0 = cyc;
    push_apb(26'h0000044, 0, 0, 4'h0, t0 + 9, 0, 0, 32'hFFFFFFFF, 0);
    issue(CMD_READ, 1'b1, 26'h0000044, 32'h0, 4'h0, 8);
    while (cyc != t0 + 14) @(negedge pclk);
    preset = 1'b1;
    @(negedge pclk);
    zero_check("rst_rdata");
    preset = 1'b0;
    @(negedge pclk);
    mon_off = 1'b0;
    wait_done("rst_rdata");
    t0 = cyc;
    push_apb(26'h0, 0, 0, 4'h0, t0 + 1, 0, 0, 32'h76543210, 0);
    push_lnk(4'b0100, 1, 32'h76543210, t0 + 3);
    issue(CMD_POLL, 1'b1, 26'h0, 32'h0, 4'h0, 0);
    wait_done("poll_after_rst_rdata");

    // Only enabled commands run
    t0 = cyc;
    push_apb(26'h00055A8, 1, 32'h600DF00D, 4'h3, t0 + 9, 0, 0, 32'h0, 0);
    push_lnk(4'b0100, 0, 32'h0, t0 + 11);
    issue(CMD_WRITE, 1'b1, 26'h00055A8, 32'h600DF00D, 4'h3, 8);
    wait_done("enable_write");
    issue(CMD_READ, 1'b0, 26'h0, 32'h0, 4'h0, 0);
    issue(CMD_POLL, 1'b0, 26'h0, 32'h0, 4'h0, 0);
    issue(CMD_WRITE, 1'b0, 26'h0, 32'h0, 4'hF, 0);
    t0 = cyc;
    push_apb(26'h00055A8, 0, 0, 4'h0, t0 + 1, 0, 0, 32'h0BADCAFE, 0);
    push_lnk(4'b0100, 1, 32'h0BADCAFE, t0 + 3);
    issue(CMD_POLL, 1'b1, 26'h0, 32'h0, 4'h0, 0);
    wait_done("enable_poll");

    repeat (20) @(negedge pclk);
    chk("apb_queue_empty", apb_q.size(), 0);
    chk("lnk_queue_empty", lnk_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/g5_apblink_slave.md
# g5_apblink_slave

Far-end terminator of the 4-bit G5 APBLink serial link. Decodes link commands (WRITE, READ, POLL), deserialises address and write data, and replays each transfer as an APB master cycle on a local 26-bit APB target bus. Returns the ready/error marker and serialised read data to the link initiator. Sits inside the target IP, clocked from the link clock.

## Interface
- TIMEOUT_CYCLES, 1024: max ACCESS cycles waiting for m_pready; 0 disables the timeout.
- pclk  in  1  link/APB clock (same clock as the initiator's link clock)
- preset  in  1  synchronous, active-high reset
- lnk_s_enable  in  1  link enable; sampled only in S_IDLE
- lnk_s_addr  in  3  command / address lanes
- lnk_s_wdata  in  4  strobe / write-data lanes
- lnk_s_rdata  out  4  marker / read-data lanes, registered
- m_psel, m_penable, m_pwrite  out  1 each  APB master controls
- m_paddr  out  26  {addr[25:2], 2'b00}
- m_pwdata  out  32  write data
- m_pstrb  out  4  byte strobes; 4'h0 on reads
- m_prdata  in  32  read data
- m_pready, m_pslverr  in  1 each  APB completion / error

## Operation
- Commands on lnk_s_addr[1:0] in S_IDLE: 00 NOOP, 10 WRITE, 01 READ, 11 POLL. lnk_s_addr[2] ignored. Command accepted only if lnk_s_enable=1.
- On WRITE/READ: capture lnk_s_wdata as strobe and pwrite, then enter S_ADDR.
- S_ADDR: cnt i=0..7, one cycle each:
  - addr[2+i]=lnk_s_addr[0], addr[10+i]=lnk_s_addr[1], addr[18+i]=lnk_s_addr[2].
  - wdata[8k+i]=lnk_s_wdata[k], k=0..3.
  - After i=7: go to S_SETUP; captured address becomes held address.
- POLL: read of the held address; go directly to S_SETUP, pwrite=0.
- Held address resets to 0, so a POLL straight after reset reads address 0.
- S_SETUP: m_psel=1, m_penable=0 for one cycle, then S_ACCESS.
- S_ACCESS: m_psel=m_penable=1 until m_pready=1.
  - Then capture m_prdata and m_pslverr, drop psel/penable, go to S_MARK.
  - If TIMEOUT_CYCLES cycles elapse with no pready: drop psel/penable, set err=1, read data=0, go to S_MARK.
- S_MARK: lnk_s_rdata={err,1,0,0} for exactly one cycle.
  - Write: then S_IDLE.
  - Read/POLL: then S_RDATA.
- S_RDATA: cnt i=0..7, lnk_s_rdata[k]=rdata[8k+i], then S_IDLE.
- Outside S_MARK/S_RDATA: lnk_s_rdata=4'h0.
- Link inputs are ignored outside S_IDLE/S_ADDR.
- Reset (including mid-transfer): all outputs 0, state S_IDLE, held address 0, counters 0. An in-flight APB cycle is abandoned.

## Timing
- Command sampled in cycle T0.
  - WRITE/READ: S_ADDR T1–T8, S_SETUP T9, S_ACCESS from T10.
  - POLL: S_SETUP T1, S_ACCESS from T2.
- pready sampled high in cycle A gives S_MARK in A+1 and read lanes in A+2..A+9.
- Marker can never precede the initiator's access state (its earliest sample point is T10, or T2 for POLL). The marker is never lost.
- Return to S_IDLE:
  - Write: A+2; next command accepted from A+2.
  - Read: A+10.
- m_paddr, m_pwdata, m_pstrb and m_pwrite are stable from S_SETUP through the end of S_ACCESS.
- Minimum write latency, command to marker: 11 cycles.

## Structure
- Package g5_apblink_pkg:
  - command localparams NOOP/WRITE/READ/POLL
  - state enumeration
  - marker bit positions (rdy=2, err=3)
  - the initiator is moved onto the same package
- Sub-module g5_apblink_lane_deser: 3-bit counter plus the 24-bit address and 32-bit data deserialiser, with load/shift enables.
- FSM, APB sequencing, timeout counter and read serialiser stay in the top module.

## Test plan
- WRITE addr 0x0ABCDE4, data 0xA5A51234, strb 0xF, pready in first ACCESS cycle -> one APB write with those values; marker {0,1,0,0} at T11; S_IDLE at T12.
- READ addr 0x0000100, target returns 0xDEADBEEF after 3 wait cycles -> marker, then lanes [3:0] over 8 cycles rebuild 0xDEADBEEF LSB-first per byte; m_pstrb=0.
- POLL after the previous READ -> APB read of 0x0000100 with psel at T1; POLL immediately after reset -> read of 0x0000000.
- WRITE with m_pslverr=1 -> marker 4'b1100; READ with pslverr=1 -> marker 4'b1100, data still serialised.
- TIMEOUT_CYCLES=16, pready held low -> psel dropped after 16 ACCESS cycles; marker 4'b1100; read lanes all 0.
- preset asserted mid-S_ADDR and mid-S_RDATA -> next cycle all outputs 0 and S_IDLE; back-to-back WRITE then POLL with enable toggled low in idle -> only enabled commands run.
